// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the 7-segment readback path.
//   - Active-low segment patterns for digits 0..9 and the all-off blank pattern.
//   - Special decode codes for blank and illegal patterns.
//   - FSM state type for the per-dwell capture controller.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] BCD_BLANK   = 4'hF;
  localparam logic [3:0] BCD_ILLEGAL = 4'hE;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

endpackage

// File: rtl/seg_readback_if.sv
// seg_readback_if: display-bus sample inputs and reconstructed frame outputs.
//   seg_in      : active-low segment lines, bit0=a .. bit6=g
//   dig_sel     : active-high digit enables, one-hot when valid
//   bcd_out     : last complete frame, nibble i = digit i
//   frame_valid : one-cycle pulse when bcd_out updates
//   frame_err   : any slot of the frame held an illegal pattern
// master = display-side driver, slave = seg_readback.
interface seg_readback_if #(parameter int DIGITS = 4);
  logic [6:0]          seg_in;
  logic [DIGITS-1:0]   dig_sel;
  logic [4*DIGITS-1:0] bcd_out;
  logic                frame_valid;
  logic                frame_err;

  modport master (output seg_in, dig_sel, input bcd_out, frame_valid, frame_err);
  modport slave  (input seg_in, dig_sel, output bcd_out, frame_valid, frame_err);
endinterface

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: combinational inverse of the display table.
//   seg     in  7 : active-low segment pattern
//   val     out 4 : decoded digit, BCD_BLANK or BCD_ILLEGAL
//   illegal out 1 : pattern is not a recognised digit
// SEG_READBACK_BLANK_EN: when defined, all-off (7'h7F) decodes to BCD_BLANK
// and is legal; otherwise it is illegal like any unlisted pattern.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] val,
  output logic       illegal
);

`ifdef SEG_READBACK_BLANK_EN
  localparam bit BLANK_LEGAL = 1'b1;
`else
  localparam bit BLANK_LEGAL = 1'b0;
`endif

  always_comb begin
    val     = BCD_ILLEGAL;
    illegal = 1'b1;
    case (seg)
      SEG_0: begin val = 4'd0; illegal = 1'b0; end
      SEG_1: begin val = 4'd1; illegal = 1'b0; end
      SEG_2: begin val = 4'd2; illegal = 1'b0; end
      SEG_3: begin val = 4'd3; illegal = 1'b0; end
      SEG_4: begin val = 4'd4; illegal = 1'b0; end
      SEG_5: begin val = 4'd5; illegal = 1'b0; end
      SEG_6: begin val = 4'd6; illegal = 1'b0; end
      SEG_7: begin val = 4'd7; illegal = 1'b0; end
      SEG_8: begin val = 4'd8; illegal = 1'b0; end
      SEG_9: begin val = 4'd9; illegal = 1'b0; end
      default: begin
        if (BLANK_LEGAL && seg == SEG_BLANK) begin
          val     = BCD_BLANK;
          illegal = 1'b0;
        end
      end
    endcase
  end

endmodule

// File: rtl/seg_readback.sv
// seg_readback: reconstructs the BCD value shown on a multiplexed active-low
// 7-segment bus. Each digit dwell is debounced (STABLE_CYCLES identical
// samples), decoded once, and stored in its slot; when every slot has been
// seen, the slots are published as one frame.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : seg_readback_if.slave (seg_in, dig_sel in; bcd_out,
//                frame_valid, frame_err out)
// Optional feature macro: SEG_READBACK_BLANK_EN (blank pattern legal, see
// seg_pattern_decode).
module seg_readback
  import seg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  seg_readback_if.slave  bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [DIGITS-1:0]      prev_sel;
  logic [6:0]             prev_seg;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   onehot, changed, capture;
  logic [IW-1:0]          idx;
  state_t                 state, state_nxt;

  logic [DIGITS-1:0][3:0] slots;
  logic [DIGITS-1:0]      seen, err;
  logic [3:0]             dec_val;
  logic                   dec_ill;

  seg_pattern_decode u_dec (.seg(bus.seg_in), .val(dec_val), .illegal(dec_ill));

  always_comb begin
    onehot  = $onehot(bus.dig_sel);
    changed = {bus.dig_sel, bus.seg_in} != {prev_sel, prev_seg};
    // cnt_nxt counts the current sample: 1 on a fresh value, saturating after.
    if (changed || !onehot)                   cnt_nxt = CW'(1);
    else if (cnt == CW'(STABLE_CYCLES))       cnt_nxt = cnt;
    else                                      cnt_nxt = cnt + CW'(1);
    idx = '0;
    for (int i = 0; i < DIGITS; i++)
      if (bus.dig_sel[i]) idx = IW'(i);
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE:   if (onehot) state_nxt = SETTLE;
      SETTLE: begin
        if (!onehot) state_nxt = IDLE;
        else if (cnt_nxt == CW'(STABLE_CYCLES)) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!onehot)      state_nxt = IDLE;
        else if (changed) state_nxt = SETTLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_sel <= '0;
      prev_seg <= '0;
      cnt      <= '0;
      state    <= IDLE;
    end else begin
      prev_sel <= bus.dig_sel;
      prev_seg <= bus.seg_in;
      cnt      <= cnt_nxt;
      state    <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots           <= '0;
      seen            <= '0;
      err             <= '0;
      bus.bcd_out     <= '0;
      bus.frame_err   <= 1'b0;
      bus.frame_valid <= 1'b0;
    end else begin
      bus.frame_valid <= 1'b0;
      if (&seen) begin
        bus.bcd_out     <= slots;
        bus.frame_err   <= |err;
        bus.frame_valid <= 1'b1;
        seen            <= '0;
        err             <= '0;
      end
      // Placed after the frame-end clear so a same-cycle capture seeds the
      // next frame instead of being lost.
      if (capture) begin
        slots[idx] <= dec_val;
        seen[idx]  <= 1'b1;
        err[idx]   <= dec_ill;
      end
    end
  end

endmodule

// File: tb/tb_seg_readback.sv
// tb_seg_readback: directed dwell-level stimulus for seg_readback. The model
// treats each dwell (one input value held n cycles, consecutive dwells always
// different) as one capture when it is one-hot and at least STABLE cycles
// long, and predicts each frame and the cycle its pulse must appear.
module tb_seg_readback;
  import seg_pkg::*;

  localparam int DIGITS = 4;
  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_readback_if #(.DIGITS(DIGITS)) bus();

  seg_readback #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] val;
    logic        err;
    int          at;
  } frame_t;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  frame_t      exp_q[$];
  frame_t      last_push;
  frame_t      cf;
  logic        due;
  logic [15:0] cur_val = '0;

  logic [3:0][3:0] m_slots;
  logic [3:0]      m_seen, m_err;
  logic [6:0]      pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [4:0] model_decode(input logic [6:0] s);
    for (int k = 0; k < 10; k++)
      if (pat[k] == s) return {1'b0, 4'(k)};
`ifdef SEG_READBACK_BLANK_EN
    if (s == 7'h7F) return {1'b0, 4'hF};
`endif
    return {1'b1, 4'hE};
  endfunction

  // Apply one dwell starting right after a rising edge; cyc is then the index
  // of the edge just passed, so the capture edge is cyc+STABLE and the frame
  // pulse is visible during cycle cyc+STABLE+1.
  task automatic apply(input logic [3:0] sel, input logic [6:0] seg, input int n);
    logic [4:0] d;
    int         k;
    bus.dig_sel = sel;
    bus.seg_in  = seg;
    if ($onehot(sel) && n >= STABLE) begin
      k = 0;
      for (int i = 0; i < DIGITS; i++) if (sel[i]) k = i;
      d = model_decode(seg);
      m_slots[k] = d[3:0];
      m_err[k]   = d[4];
      m_seen[k]  = 1'b1;
      if (&m_seen) begin
        last_push.val = m_slots;
        last_push.err = |m_err;
        last_push.at  = cyc + STABLE + 1;
        exp_q.push_back(last_push);
        m_seen = '0;
        m_err  = '0;
      end
    end
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic scan(input logic [3:0] v0, v1, v2, v3);
    apply(4'b0001, pat[v0], 8);
    apply(4'b0010, pat[v1], 8);
    apply(4'b0100, pat[v2], 8);
    apply(4'b1000, pat[v3], 8);
    apply(4'b0000, 7'h7F, 4);
  endtask

  // Per-cycle compare: pulse exactly when predicted, frame content on the
  // pulse, bcd_out held at the last frame otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      due = (exp_q.size() > 0) && (exp_q[0].at == cyc);
      chk("frame_valid", 32'(bus.frame_valid), 32'(due));
      if (due) begin
        cf = exp_q.pop_front();
        chk("frame bcd_out", 32'(bus.bcd_out), 32'(cf.val));
        chk("frame frame_err", 32'(bus.frame_err), 32'(cf.err));
        cur_val = cf.val;
      end else begin
        chk("bcd_out hold", 32'(bus.bcd_out), 32'(cur_val));
      end
    end
  end

  initial begin
    m_slots = '0; m_seen = '0; m_err = '0;
    bus.dig_sel = '0;
    bus.seg_in  = 7'h7F;
    repeat (2) begin @(posedge clk); #1; end
    chk("reset bcd_out", 32'(bus.bcd_out), 32'h0);
    chk("reset frame_valid", 32'(bus.frame_valid), 32'h0);
    chk("reset frame_err", 32'(bus.frame_err), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic scan 5,7,6,9.
    scan(4'd5, 4'd7, 4'd6, 4'd9);
    chk("model scan", 32'(last_push.val), 32'h9675);
    chk("model scan err", 32'(last_push.err), 32'h0);
    chk("scan bcd_out", 32'(bus.bcd_out), 32'h9675);

    // Blank on digit 1.
    apply(4'b0001, SEG_1, 8);
    apply(4'b0010, SEG_BLANK, 8);
    apply(4'b0100, SEG_2, 8);
    apply(4'b1000, SEG_3, 8);
    apply(4'b0000, 7'h7F, 4);
`ifdef SEG_READBACK_BLANK_EN
    chk("blank bcd_out", 32'(bus.bcd_out), 32'h32F1);
    chk("model blank err", 32'(last_push.err), 32'h0);
`else
    chk("blank bcd_out", 32'(bus.bcd_out), 32'h32E1);
    chk("model blank err", 32'(last_push.err), 32'h1);
`endif

    // Short glitch to 8 inside a dwell on 0 is never captured.
    apply(4'b0001, SEG_0, 2);
    apply(4'b0001, SEG_8, 2);
    apply(4'b0001, SEG_0, 6);
    apply(4'b0010, SEG_1, 8);
    apply(4'b0100, SEG_2, 8);
    apply(4'b1000, SEG_3, 8);
    apply(4'b0000, 7'h7F, 4);
    chk("glitch bcd_out", 32'(bus.bcd_out), 32'h3210);

    // Overlapping selects capture nothing.
    apply(4'b0011, SEG_8, 10);
    scan(4'd4, 4'd3, 4'd2, 4'd1);
    chk("overlap bcd_out", 32'(bus.bcd_out), 32'h1234);

    // Digit 2 revisited before digit 3: overwrite, single frame.
    apply(4'b0001, SEG_7, 8);
    apply(4'b0100, SEG_5, 8);
    apply(4'b0010, SEG_8, 8);
    apply(4'b0100, SEG_3, 8);
    apply(4'b1000, SEG_1, 8);
    apply(4'b0000, 7'h7F, 4);
    chk("revisit slot2", 32'(bus.bcd_out[11:8]), 32'h3);
    chk("revisit bcd_out", 32'(bus.bcd_out), 32'h1387);

    // Reset after 3 of 4 digits discards the partial frame.
    apply(4'b0001, SEG_1, 8);
    apply(4'b0010, SEG_2, 8);
    apply(4'b0100, SEG_3, 8);
    rst_n = 1'b0;
    bus.dig_sel = '0;
    bus.seg_in  = 7'h7F;
    m_slots = '0; m_seen = '0; m_err = '0;
    exp_q.delete();
    cur_val = '0;
    repeat (2) begin @(posedge clk); #1; end
    chk("mid reset bcd_out", 32'(bus.bcd_out), 32'h0);
    chk("mid reset frame_valid", 32'(bus.frame_valid), 32'h0);
    chk("mid reset frame_err", 32'(bus.frame_err), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    scan(4'd9, 4'd8, 4'd7, 4'd6);
    chk("post reset bcd_out", 32'(bus.bcd_out), 32'h6789);

    apply(4'b0000, 7'h7F, 8);
    chk("frames outstanding", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
